// File: rtl/axil_lsu_bridge.sv
// Load/store bridge from the M stage to either the local data RAM
// (combinational, zero stall) or an AXI4-Lite master port (stalls the
// pipeline until the transaction completes). Handles byte/half/word sizes,
// lane steering for 32- or 64-bit buses, and counts errors.
module axil_lsu_bridge #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] LOCAL_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] LOCAL_MASK = 32'hFFFF_F000,
  parameter logic [2:0]        AXPROT     = 3'b000,
  parameter int unsigned       ERRCNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [2:0]            req_funct3,
  output logic [31:0]           rsp_rdata,
  output logic                  stall_axi,
  output logic                  bus_err,
  output logic [ERRCNT_W-1:0]   err_count,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_write_data,
  output logic                  ram_write_en,
  output logic [DATA_W/8-1:0]   ram_wstrb,
  input  logic [DATA_W-1:0]     ram_read_data,
  output logic                  awvalid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [2:0]            awprot,
  input  logic                  awready,
  output logic                  wvalid,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wready,
  input  logic                  bvalid,
  input  logic [1:0]            bresp,
  output logic                  bready,
  output logic                  arvalid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [2:0]            arprot,
  input  logic                  arready,
  input  logic                  rvalid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  output logic                  rready
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned OFF_W   = $clog2(STRB_W);
  localparam int unsigned NLANE32 = DATA_W / 32;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  // funct3[1:0] is the size; bit 2 only selects zero-extension on loads.
  function automatic logic is_legal(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: is_legal = 1'b1;
      3'b001, 3'b101: is_legal = ~a[0];
      3'b010:         is_legal = (a == 2'b00);
      default:        is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [STRB_W-1:0] mk_strb(input logic [2:0] f3,
                                                input logic [OFF_W-1:0] off);
    logic [STRB_W-1:0] base;
    case (f3[1:0])
      2'b00:   base = STRB_W'(4'b0001);
      2'b01:   base = STRB_W'(4'b0011);
      default: base = STRB_W'(4'b1111);
    endcase
    mk_strb = base << off;
  endfunction

  // Store data is replicated so the strobe alone picks the lane.
  function automatic logic [DATA_W-1:0] mk_wdata(input logic [2:0] f3,
                                                 input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    mk_wdata = {NLANE32{w}};
  endfunction

  function automatic logic [31:0] ext_load(input logic [DATA_W-1:0] d,
                                           input logic [OFF_W-1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] sh;
    sh = 32'(d >> {off, 3'b000});
    case (f3[1:0])
      2'b00:   ext_load = {{24{sh[7]  & ~f3[2]}}, sh[7:0]};
      2'b01:   ext_load = {{16{sh[15] & ~f3[2]}}, sh[15:0]};
      default: ext_load = sh;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [2:0]          f3_q, f3_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                rerr_q, rerr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

  logic              hit, legal, idle, loc_go, ext_go, ill;
  logic [STRB_W-1:0] strb;
  logic [DATA_W-1:0] st_data;

  assign hit     = ((req_addr & LOCAL_MASK) == LOCAL_BASE);
  assign legal   = is_legal(req_funct3, req_addr[1:0]);
  // Reset also silences the combinational local/illegal paths.
  assign idle    = (state_q == S_IDLE) & ~reset;
  assign loc_go  = idle & req_valid & hit & legal;
  assign ext_go  = idle & req_valid & ~hit & legal;
  assign ill     = idle & req_valid & ~legal;
  assign strb    = mk_strb(req_funct3, req_addr[OFF_W-1:0]);
  assign st_data = mk_wdata(req_funct3, req_wdata);

  assign ram_addr       = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign ram_write_data = st_data;
  assign ram_write_en   = loc_go & req_write;
  assign ram_wstrb      = loc_go ? strb : '0;

  assign stall_axi = (~reset & req_valid & ~hit & legal & (state_q != S_DONE)) | busy_q;
  assign bus_err   = ill | ((state_q == S_DONE) & rerr_q);
  assign rsp_rdata = (state_q == S_DONE) ? rdata_q :
                     loc_go ? ext_load(ram_read_data, req_addr[OFF_W-1:0], req_funct3) :
                     32'h0;
  assign err_count = errcnt_q;

  assign awaddr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign araddr = awaddr;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign awprot = AXPROT;
  assign arprot = AXPROT;

  // State and latched-request registers; reset abandons any transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      f3_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rerr_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      f3_q      <= f3_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rerr_q    <= rerr_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next state and AXI channel handshakes.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    f3_d      = f3_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rerr_d    = rerr_q;
    rdata_d   = rdata_q;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ext_go) begin
          addr_d    = req_addr;
          wdata_d   = st_data;
          wstrb_d   = strb;
          f3_d      = req_funct3;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rerr_d    = 1'b0;
          rdata_d   = '0;
          busy_d    = 1'b1;
          state_d   = req_write ? S_WR : S_RD_ADDR;
        end
      end
      S_WR: begin
        // AW and W complete independently, possibly in the same cycle.
        awvalid   = ~aw_done_q;
        wvalid    = ~w_done_q;
        aw_done_d = aw_done_q | (awvalid & awready);
        w_done_d  = w_done_q | (wvalid & wready);
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          rerr_d  = (bresp == 2'b10) | (bresp == 2'b11);
          rdata_d = '0;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          rerr_d  = (rresp == 2'b10) | (rresp == 2'b11);
          rdata_d = rresp[1] ? 32'h0 : ext_load(rdata, addr_q[OFF_W-1:0], f3_q);
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating error counter, one step per bus_err pulse.
  always_comb begin
    errcnt_d = errcnt_q;
    if (bus_err && (errcnt_q != '1)) errcnt_d = errcnt_q + ERRCNT_W'(1);
  end

  // Error counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) errcnt_q <= '0;
    else       errcnt_q <= errcnt_d;
  end

endmodule

// File: tb/tb_axil_lsu_bridge.sv
// Scoreboard bench for axil_lsu_bridge: a 32-bit instance with RAM and
// AXI slave models, plus a 64-bit instance for wide-bus load lanes.
module tb_axil_lsu_bridge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- 32-bit instance ----------------
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic [31:0] rsp_rdata;
  logic        stall_axi, bus_err;
  logic [7:0]  err_count;
  logic [31:0] ram_addr, ram_write_data, ram_read_data;
  logic        ram_write_en;
  logic [3:0]  ram_wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axil_lsu_bridge u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_rdata(rsp_rdata), .stall_axi(stall_axi), .bus_err(bus_err), .err_count(err_count),
    .ram_addr(ram_addr), .ram_write_data(ram_write_data), .ram_write_en(ram_write_en),
    .ram_wstrb(ram_wstrb), .ram_read_data(ram_read_data),
    .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arprot(arprot), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready)
  );

  // Local RAM model: async read, byte-enabled write.
  logic [31:0] mem [0:255] = '{default: 32'h0};
  assign ram_read_data = mem[ram_addr[9:2]];
  always @(posedge clk)
    if (ram_write_en)
      for (int b = 0; b < 4; b++)
        if (ram_wstrb[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_write_data[8*b +: 8];

  // AXI-Lite slave model with configurable AW/W ready delay and B hold.
  int          aw_dly = 0, w_dly = 0;
  logic        b_hold = 1'b0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 32'h0;
  int          aw_wait, w_wait, cyc = 0;
  logic        aw_got, w_got, b_pend, r_pend;
  logic        aw_pp, w_pp, ar_pp;
  int          b_hs = 0, valid_seen = 0, viol = 0, aw_hs_cyc = 0, w_hs_cyc = 0;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;

  assign awready = awvalid && (aw_wait >= aw_dly);
  assign wready  = wvalid && (w_wait >= w_dly);
  assign bvalid  = b_pend && !b_hold;
  assign bresp   = b_resp_cfg;
  assign arready = arvalid;
  assign rvalid  = r_pend;
  assign rdata   = r_data_cfg;
  assign rresp   = r_resp_cfg;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_wait <= 0; w_wait <= 0; aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
      aw_pp <= 0; w_pp <= 0; ar_pp <= 0;
    end else begin
      cyc     <= cyc + 1;
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
      if (awvalid || wvalid || arvalid) valid_seen <= valid_seen + 1;
      // a valid that was pending must still be high
      if ((aw_pp && !awvalid) || (w_pp && !wvalid) || (ar_pp && !arvalid)) viol <= viol + 1;
      aw_pp <= awvalid && !awready;
      w_pp  <= wvalid && !wready;
      ar_pp <= arvalid && !arready;
      if (awvalid && awready) begin aw_hs_cyc <= cyc; cap_awaddr <= awaddr; end
      if (wvalid && wready) begin w_hs_cyc <= cyc; cap_wdata <= wdata; cap_wstrb <= wstrb; end
      if (bvalid && bready) begin
        b_pend <= 0; b_hs <= b_hs + 1;
      end else if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        b_pend <= 1; aw_got <= 0; w_got <= 0;
      end else begin
        aw_got <= aw_got || (awvalid && awready);
        w_got  <= w_got || (wvalid && wready);
      end
      if (arvalid && arready) begin r_pend <= 1; cap_araddr <= araddr; end
      else if (rvalid && rready) r_pend <= 0;
    end
  end

  // ---------------- 64-bit instance (load lanes) ----------------
  logic        req64_valid, req64_write;
  logic [31:0] req64_addr, req64_wdata;
  logic [2:0]  req64_funct3;
  logic [31:0] rsp64_rdata;
  logic        stall64, bus_err64;
  logic [7:0]  err_count64;
  logic [31:0] ram64_addr;
  logic [63:0] ram64_wdata, ram64_rdata;
  logic        ram64_we;
  logic [7:0]  ram64_wstrb;
  logic        awvalid64, awready64, wvalid64, wready64, bvalid64, bready64;
  logic        arvalid64, arready64, rvalid64, rready64;
  logic [31:0] awaddr64, araddr64;
  logic [63:0] wdata64, rdata64;
  logic [7:0]  wstrb64;
  logic [2:0]  awprot64, arprot64;
  logic [1:0]  bresp64, rresp64;
  logic        r64_pend;
  logic [63:0] r64_data = 64'h0;
  logic [31:0] cap_araddr64;

  axil_lsu_bridge #(.DATA_W(64)) u_dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req64_valid), .req_write(req64_write), .req_addr(req64_addr),
    .req_wdata(req64_wdata), .req_funct3(req64_funct3),
    .rsp_rdata(rsp64_rdata), .stall_axi(stall64), .bus_err(bus_err64), .err_count(err_count64),
    .ram_addr(ram64_addr), .ram_write_data(ram64_wdata), .ram_write_en(ram64_we),
    .ram_wstrb(ram64_wstrb), .ram_read_data(ram64_rdata),
    .awvalid(awvalid64), .awaddr(awaddr64), .awprot(awprot64), .awready(awready64),
    .wvalid(wvalid64), .wdata(wdata64), .wstrb(wstrb64), .wready(wready64),
    .bvalid(bvalid64), .bresp(bresp64), .bready(bready64),
    .arvalid(arvalid64), .araddr(araddr64), .arprot(arprot64), .arready(arready64),
    .rvalid(rvalid64), .rdata(rdata64), .rresp(rresp64), .rready(rready64)
  );

  assign ram64_rdata = 64'h0;
  assign awready64   = 1'b1;
  assign wready64    = 1'b1;
  assign bvalid64    = 1'b0;
  assign bresp64     = 2'b00;
  assign arready64   = arvalid64;
  assign rvalid64    = r64_pend;
  assign rdata64     = r64_data;
  assign rresp64     = 2'b00;

  always @(posedge clk or posedge reset) begin
    if (reset) r64_pend <= 0;
    else if (arvalid64 && arready64) begin r64_pend <= 1; cap_araddr64 <= araddr64; end
    else if (rvalid64 && rready64) r64_pend <= 0;
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_err = 0, err_model = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rd;
    logic        use_rd;
    logic        err;
    int          st;
  } exp_t;
  exp_t exp_q[$];

  logic        last_we;
  logic [3:0]  last_wstrb;
  logic [31:0] last_waddr, last_wdat;

  // Drive one request on the 32-bit instance, compare when stall drops.
  task automatic run_req(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f3,
                         input logic [31:0] exp_rd, input logic use_rd,
                         input logic exp_err, input int exp_st);
    int st; bit done; exp_t e;
    st = 0; done = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f3;
    exp_q.push_back('{exp_rd, use_rd, exp_err, exp_st});
    if (exp_err && err_model != 255) err_model++;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (!stall_axi) begin
        e = exp_q.pop_front();
        if (e.use_rd) chk({tag, "/rdata"}, rsp_rdata, e.rd);
        chk({tag, "/bus_err"}, bus_err, e.err);
        chk({tag, "/stall"}, st, e.st);
        last_we = ram_write_en; last_wstrb = ram_wstrb;
        last_waddr = ram_addr; last_wdat = ram_write_data;
        done = 1;
      end else st++;
      @(negedge clk);
    end
    chk({tag, "/done"}, done, 1);
    if (!done) exp_q.delete();
    req_valid = 0;
  endtask

  task automatic run_rd64(input string tag, input logic [31:0] a, input logic [2:0] f3,
                          input logic [63:0] rd64, input logic [31:0] exp_rd,
                          input logic [31:0] exp_ar);
    int st; bit done; exp_t e;
    st = 0; done = 0;
    r64_data = rd64;
    req64_valid = 1; req64_addr = a; req64_funct3 = f3;
    exp_q.push_back('{exp_rd, 1'b1, 1'b0, 3});
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (!stall64) begin
        e = exp_q.pop_front();
        chk({tag, "/rdata"}, rsp64_rdata, e.rd);
        chk({tag, "/bus_err"}, bus_err64, e.err);
        chk({tag, "/stall"}, st, e.st);
        done = 1;
      end else st++;
      @(negedge clk);
    end
    chk({tag, "/done"}, done, 1);
    if (!done) exp_q.delete();
    chk({tag, "/araddr"}, cap_araddr64, exp_ar);
    req64_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bh, vs;
    reset = 1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
    req64_valid = 0; req64_write = 0; req64_addr = 0; req64_wdata = 0; req64_funct3 = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst/valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst/stall_err", {stall_axi, bus_err, ram_write_en}, 0);
    chk("rst/ram_wstrb", ram_wstrb, 0);
    chk("rst/rsp_rdata", rsp_rdata, 0);
    chk("rst/err_count", err_count, 0);
    chk("rst/prot", {awprot, arprot}, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);

    // local accesses
    run_req("sw_loc", 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1, 0, 0);
    chk("sw_loc/wstrb", last_wstrb, 4'b1111);
    chk("sw_loc/we", last_we, 1);
    chk("sw_loc/wdata", last_wdat, 32'hDEADBEEF);
    run_req("lb_loc", 0, 32'h11, 0, 3'b000, 32'hFFFFFFBE, 1, 0, 0);
    chk("lb_loc/we", last_we, 0);
    run_req("lbu_loc", 0, 32'h13, 0, 3'b100, 32'h000000DE, 1, 0, 0);
    run_req("lh_loc", 0, 32'h12, 0, 3'b001, 32'hFFFFDEAD, 1, 0, 0);
    run_req("lhu_loc", 0, 32'h10, 0, 3'b101, 32'h0000BEEF, 1, 0, 0);
    run_req("sb_loc", 1, 32'h13, 32'h55, 3'b000, 32'hFFFFFFDE, 1, 0, 0);
    chk("sb_loc/wstrb", last_wstrb, 4'b1000);
    chk("sb_loc/wdata", last_wdat, 32'h55555555);
    chk("sb_loc/addr", last_waddr, 32'h10);
    run_req("lw_loc", 0, 32'h10, 0, 3'b010, 32'h55ADBEEF, 1, 0, 0);

    // external store, AW delayed two cycles, W immediate
    bh = b_hs; aw_dly = 2; w_dly = 0;
    run_req("sh_ext", 1, 32'h4000_0002, 32'h1234, 3'b001, 32'h0, 0, 0, 5);
    chk("sh_ext/awaddr", cap_awaddr, 32'h4000_0000);
    chk("sh_ext/wdata", cap_wdata, 32'h12341234);
    chk("sh_ext/wstrb", cap_wstrb, 4'b1100);
    chk("sh_ext/w_before_aw", w_hs_cyc < aw_hs_cyc, 1);
    chk("sh_ext/b_once", b_hs - bh, 1);
    aw_dly = 0;
    run_req("sb_ext", 1, 32'h4000_0005, 32'hAB, 3'b000, 32'h0, 0, 0, 3);
    chk("sb_ext/awaddr", cap_awaddr, 32'h4000_0004);
    chk("sb_ext/wdata", cap_wdata, 32'hABABABAB);
    chk("sb_ext/wstrb", cap_wstrb, 4'b0010);

    // external loads
    r_data_cfg = 32'hCAFEF00D;
    run_req("lw_ext", 0, 32'h4000_0008, 0, 3'b010, 32'hCAFEF00D, 1, 0, 3);
    chk("lw_ext/araddr", cap_araddr, 32'h4000_0008);
    r_data_cfg = 32'h80FF_FFFF;
    run_req("lb_ext", 0, 32'h4000_000B, 0, 3'b000, 32'hFFFFFF80, 1, 0, 3);
    chk("lb_ext/araddr", cap_araddr, 32'h4000_0008);

    // illegal requests
    vs = valid_seen;
    run_req("lw_mis", 0, 32'h4000_0003, 0, 3'b010, 32'h0, 1, 1, 0);
    chk("lw_mis/no_axi", valid_seen - vs, 0);
    chk("lw_mis/err_count", err_count, 1);
    run_req("f3_011", 1, 32'h10, 32'h0, 3'b011, 32'h0, 1, 1, 0);
    chk("f3_011/we", {last_we, last_wstrb}, 0);
    run_req("sh_odd", 1, 32'h11, 32'h0, 3'b001, 32'h0, 1, 1, 0);
    chk("sh_odd/err_count", err_count, err_model);

    // slave error response on a load
    r_data_cfg = 32'h12345678; r_resp_cfg = 2'b10;
    run_req("lw_slverr", 0, 32'h4000_0010, 0, 3'b010, 32'h0, 1, 1, 3);
    r_resp_cfg = 2'b00;
    chk("lw_slverr/err_count", err_count, err_model);

    // saturation
    for (int i = 0; i < 256; i++)
      run_req("ill_loop", 0, 32'h4000_0000, 0, 3'b111, 32'h0, 1, 1, 0);
    chk("sat/err_count", err_count, 255);
    chk("sat/model", err_count, err_model);

    // reset while waiting in WR_RESP
    b_hold = 1;
    req_valid = 1; req_write = 1; req_addr = 32'h4000_0020; req_wdata = 32'h1; req_funct3 = 3'b010;
    for (int c = 0; c < 20 && !bready; c++) begin
      @(negedge clk); #1;
    end
    chk("rst_mid/in_wr_resp", bready, 1);
    reset = 1;
    #1;
    chk("rst_mid/drop", {awvalid, wvalid, bready, stall_axi}, 0);
    chk("rst_mid/err_count", err_count, 0);
    req_valid = 0; b_hold = 0; err_model = 0;
    @(negedge clk); @(negedge clk);
    reset = 0;
    @(negedge clk);
    run_req("lw_after_rst", 0, 32'h10, 0, 3'b010, 32'h55ADBEEF, 1, 0, 0);

    // 64-bit bus lanes
    run_rd64("lhu64", 32'h4000_0006, 3'b101, 64'h8001_0000_0000_0000, 32'h0000_8001, 32'h4000_0000);
    run_rd64("lh64", 32'h4000_0006, 3'b001, 64'h8001_0000_0000_0000, 32'hFFFF_8001, 32'h4000_0000);
    run_rd64("lw64_hi", 32'h4000_000C, 3'b010, 64'h89AB_CDEF_0123_4567, 32'h89AB_CDEF, 32'h4000_0008);

    chk("proto/valid_drop", viol, 0);
    chk("sb/empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/axil_lsu_bridge.md
Name: axil_lsu_bridge

Overview:
Parametrised load/store unit bridge between the pipelined core's M stage and memory. Each request goes to one of two targets. Requests inside a local window go to the tightly coupled data RAM with zero stall. All other requests become AXI4-Lite master transactions, and the pipeline is stalled until the transaction completes. Unlike the single-width, word-only bridge it replaces, it adds:
- byte and halfword strobes with sign/zero extension
- 32- or 64-bit data buses
- independent AW/W channels
- alignment and response-error detection with a saturating error counter

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, RAM and AXI data width; legal values are 32 and 64.
LOCAL_BASE, 32'h0000_0000, base address of the local RAM window.
LOCAL_MASK, 32'hFFFF_F000, window hit when (req_addr & LOCAL_MASK) == LOCAL_BASE.
AXPROT, 3'b000, value driven on awprot and arprot.
ERRCNT_W, 8, width of the error counter.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  memory operation present in M stage; held stable while stall_axi=1
req_write  in  1  1=store, 0=load
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (rs2)
req_funct3  in  3  RV32I load/store size code
rsp_rdata  out  32  extended load result
stall_axi  out  1  freeze F/D/E/M stages
bus_err  out  1  single-cycle error pulse
err_count  out  ERRCNT_W  saturating count of errors
ram_addr  out  ADDR_W  local RAM address, lane-aligned
ram_write_data  out  DATA_W  local RAM write data
ram_write_en  out  1  local RAM write enable
ram_wstrb  out  DATA_W/8  local RAM byte enables
ram_read_data  in  DATA_W  local RAM asynchronous read data
awvalid out 1; awaddr out ADDR_W; awprot out 3; awready in 1
wvalid out 1; wdata out DATA_W; wstrb out DATA_W/8; wready in 1
bvalid in 1; bresp in 2; bready out 1
arvalid out 1; araddr out ADDR_W; arprot out 3; arready in 1
rvalid in 1; rdata in DATA_W; rresp in 2; rready out 1

Behaviour:
- Reset: asynchronous and active-high; state IDLE. All valid/ready outputs, stall_axi, bus_err, ram_write_en and ram_wstrb are 0. rsp_rdata=0 and err_count=0. Reset mid-transaction abandons the transaction immediately.
- Size decode:
  - funct3 000/100 = byte, 001/101 = half, 010 = word. Bit 2 set selects zero-extension (loads only).
  - Any other code (011, 110, 111), a half at addr[0]=1, or a word at addr[1:0]!=0 is illegal.
  - An illegal request issues no RAM or AXI access. It produces bus_err=1 for one cycle, stall_axi=0 and rsp_rdata=0.
- Lane: low byte offset = addr[log2(DATA_W/8)-1:0]. The bus address has those bits cleared. Store data is replicated across all lanes. The strobe is 1, 2 or 4 ones shifted left by the offset. Load data is taken from rdata >> (8*offset), then sign- or zero-extended to 32 bits.
- Local hit: fully combinational, with no state change.
  - ram_write_en = req_valid & req_write.
  - ram_wstrb is the computed strobe when req_valid, else 0.
  - rsp_rdata is the extended ram_read_data.
  - stall_axi=0.
- External access:
  - stall_axi = (req_valid & ~hit & legal & state!=DONE), OR'd with the registered busy flag.
  - rsp_rdata is driven from a register during DONE.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE.
  - IDLE: an external, legal req_valid loads the addr/data/strobe/funct3 registers. A store goes to WR and a load goes to RD_ADDR. Both transitions are registered, so valids first rise one cycle after the request.
  - WR: awvalid and wvalid assert together. Each drops on its own handshake (valid&ready), tracked by the aw_done and w_done flags. When both handshakes are complete (same cycle allowed), go to WR_RESP.
  - WR_RESP: bready=1. On bvalid, capture bresp and go to DONE.
  - RD_ADDR: arvalid=1. On arready, go to RD_DATA.
  - RD_DATA: rready=1. On rvalid, capture the extended lane data (0 if rresp[1]=1) and rresp, then go to DONE.
  - DONE: lasts one cycle. stall_axi=0 and rsp_rdata is valid. bus_err=1 if the captured resp[1]=1 (SLVERR or DECERR). Then go to IDLE unconditionally.
- Valids never deassert before their handshake completes. awaddr, wdata, wstrb and araddr are stable while the corresponding valid is high.
- Latency with ready tied high:
  - store: 3 stall cycles (IDLE→WR→WR_RESP→DONE)
  - load: 3 stall cycles
  - local: 0 stall cycles
- err_count increments on every bus_err pulse and saturates at all-ones.
- A req_valid change while the FSM is busy is a protocol violation and is ignored; the latched request is used.

Test Plan:
- Local SW to 0x0000_0010 with data 0xDEADBEEF, then LB from 0x11: ram_wstrb=4'b1111 with zero stall; the load returns rsp_rdata=0xFFFFFFBE in the same cycle.
- External SH of 0x1234 to 0x4000_0002 (DATA_W=32), with awready delayed 2 cycles and wready immediate: wstrb=4'b1100, wdata=0x12341234, awaddr=0x4000_0000. The W handshake completes first and AW follows. stall_axi holds until DONE and bvalid is accepted exactly once.
- External LHU from 0x4000_0006 with DATA_W=64 and rdata=0x8001_0000_0000_0000: rsp_rdata=0x00008001. With funct3=001 the result is 0xFFFF8001.
- LW at 0x4000_0003: no AXI valid asserted, bus_err pulses once, err_count increments 0→1, no stall.
- External load answered with rresp=2'b10: DONE cycle shows bus_err=1 and rsp_rdata=0. Also, 256 consecutive errors with ERRCNT_W=8 leave err_count=255.
- Reset asserted while in WR_RESP: awvalid, wvalid, bready and stall_axi drop asynchronously, and a following local access proceeds normally.
